seq_det_multi: RTL and testbench



---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_det_match.sv | 41 ++++
 rtl/seq_det_multi.sv | 135 +++++++++++++
 tb/tb_seq_det_multi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
//   Shared definitions for the multi-pattern serial detector:
//   - PAT_W_MAX    : widest pattern the slot storage can hold (N <= PAT_W_MAX)
//   - PAT_INIT_DEF : default reset value of every pattern slot
//   - pat_cfg_t    : one pattern/mask pair as stored per slot
//   - idx_w()      : width of the slot-select port, never less than 1 bit
// ---------------------------------------------------------------------------
package seq_det_pkg;

   localparam int         PAT_W_MAX    = 32;
   localparam logic [3:0] PAT_INIT_DEF = 4'b1011;

   // Pattern and mask are held zero-extended to PAT_W_MAX. The unused upper
   // mask bits are always 0, so they never take part in a comparison.
   typedef struct packed {
      logic [PAT_W_MAX-1:0] pat;
      logic [PAT_W_MAX-1:0] mask;
   } pat_cfg_t;

   function automatic int idx_w(input int num_pat);
      return (num_pat > 1) ? $clog2(num_pat) : 1;
   endfunction

endpackage

// File: rtl/seq_det_match.sv
// ---------------------------------------------------------------------------
// seq_det_match
//   One pattern slot: a masked comparison of the next history against the
//   slot's pattern, and the registered one-cycle detect pulse.
//
//   clk, rstn    : clock, asynchronous active-low reset
//   nxt_shift_i  : history including the bit shifted in on this edge
//                  (zero-extended to PAT_W_MAX)
//   cfg_i        : pattern/mask pair of this slot
//   fire_i       : edge qualifier (valid bit, history full, no clear)
//   hit_o        : combinational hit for this edge
//   det_o        : registered detect pulse
// ---------------------------------------------------------------------------
module seq_det_match
   import seq_det_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [PAT_W_MAX-1:0] nxt_shift_i,
   input  pat_cfg_t             cfg_i,
   input  logic                 fire_i,
   output logic                 hit_o,
   output logic                 det_o
);

   logic det_q;

   // Mask bits at 0 are don't-care; an all-zero mask hits on every fire.
   assign hit_o = fire_i & (((nxt_shift_i ^ cfg_i.pat) & cfg_i.mask) == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         det_q <= 1'b0;
      end else begin
         det_q <= hit_o;
      end
   end

   assign det_o = det_q;

endmodule

// File: rtl/seq_det_multi.sv
// ---------------------------------------------------------------------------
// seq_det_multi
//   Serial pattern detector with NUM_PAT runtime-programmable, bit-maskable
//   patterns of length N. The newest bit enters at the LSB of the history.
//   No hit is reported until N valid bits have been collected since reset,
//   clear or (in non-overlap mode) the last hit. A saturating counter counts
//   edges on which any slot hit.
//
//   clk, rstn    : clock, asynchronous active-low reset
//   xin_vld, xin : serial bit and its qualifier
//   clr          : synchronous clear of history, fill, counter, detects
//   overlap      : 1 = overlapping matches, 0 = restart history after a hit
//   cfg_we       : write cfg_pattern/cfg_mask into slot cfg_idx
//   cfg_idx      : slot select (out-of-range indices are ignored)
//   cfg_pattern  : pattern, MSB = oldest bit
//   cfg_mask     : 1 = compare bit, 0 = don't care
//   det_o        : per-slot one-cycle detect pulse
//   det_any      : OR of det_o, registered alongside it
//   hit_cnt      : saturating count of hit edges
// ---------------------------------------------------------------------------
module seq_det_multi
   import seq_det_pkg::*;
#(
   parameter  int           N        = 4,
   parameter  int           NUM_PAT  = 2,
   parameter  int           CNT_W    = 8,
   parameter  logic [N-1:0] PAT_INIT = N'(PAT_INIT_DEF),
   localparam int           IDX_W    = idx_w(NUM_PAT)
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               xin_vld,
   input  logic               xin,
   input  logic               clr,
   input  logic               overlap,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [N-1:0]       cfg_pattern,
   input  logic [N-1:0]       cfg_mask,
   output logic [NUM_PAT-1:0] det_o,
   output logic               det_any,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam int                FILL_W    = $clog2(N + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam pat_cfg_t          CFG_RST   = '{pat:  PAT_W_MAX'(PAT_INIT),
                                               mask: PAT_W_MAX'({N{1'b1}})};

   logic [N-1:0]         shift_q, shift_d, nxt_shift;
   logic [PAT_W_MAX-1:0] nxt_shift_ext;
   logic [FILL_W-1:0]    fill_q, fill_d, nxt_fill;
   logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
   logic                 det_any_q, det_any_d;
   pat_cfg_t             cfg_q [NUM_PAT];
   pat_cfg_t             cfg_d [NUM_PAT];
   logic [NUM_PAT-1:0]   hit_vec;
   logic                 any_hit;
   logic                 fire;

   assign nxt_shift     = {shift_q[N-2:0], xin};
   assign nxt_shift_ext = PAT_W_MAX'(nxt_shift);
   assign nxt_fill      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

   // A comparison is only legal once the history holds N fresh bits; this
   // keeps patterns such as all-zeros from hitting on the cleared history.
   assign fire    = xin_vld & ~clr & (nxt_fill == FILL_FULL);
   assign any_hit = |hit_vec;

   // Per-slot comparators; each one uses the configuration registered before
   // this edge, so a write on the hit edge still compares against the old one.
   for (genvar g = 0; g < NUM_PAT; g++) begin : g_slot
      seq_det_match u_match (
         .clk         (clk),
         .rstn        (rstn),
         .nxt_shift_i (nxt_shift_ext),
         .cfg_i       (cfg_q[g]),
         .fire_i      (fire),
         .hit_o       (hit_vec[g]),
         .det_o       (det_o[g])
      );
   end

   always_comb begin
      shift_d   = shift_q;
      fill_d    = fill_q;
      hit_cnt_d = hit_cnt_q;
      det_any_d = any_hit;
      cfg_d     = cfg_q;

      if (clr) begin
         shift_d   = '0;
         fill_d    = '0;
         hit_cnt_d = '0;
      end else if (xin_vld) begin
         shift_d = nxt_shift;
         // Non-overlap mode: the next hit must be built from N new bits.
         fill_d  = (any_hit && !overlap) ? '0 : nxt_fill;
         if (any_hit && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
         end
      end

      // Configuration writes are independent of clr. Indices that match no
      // slot simply write nothing.
      for (int i = 0; i < NUM_PAT; i++) begin
         if (cfg_we && (cfg_idx == IDX_W'(i))) begin
            cfg_d[i] = '{pat: PAT_W_MAX'(cfg_pattern), mask: PAT_W_MAX'(cfg_mask)};
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_q   <= '0;
         fill_q    <= '0;
         hit_cnt_q <= '0;
         det_any_q <= 1'b0;
         for (int i = 0; i < NUM_PAT; i++) begin
            cfg_q[i] <= CFG_RST;
         end
      end else begin
         shift_q   <= shift_d;
         fill_q    <= fill_d;
         hit_cnt_q <= hit_cnt_d;
         det_any_q <= det_any_d;
         cfg_q     <= cfg_d;
      end
   end

   assign det_any = det_any_q;
   assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_multi.sv
// ---------------------------------------------------------------------------
// tb_seq_det_multi
//   Two detector instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
//   Hand-derived vector tables and directed sequences are followed by random
//   traffic; every edge is also compared against a queue-based reference
//   model of the detection rules.
// ---------------------------------------------------------------------------
module tb_seq_det_multi;

   localparam int N  = 4;
   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          xin_vld = 1'b0;
   logic          xin = 1'b0;
   logic          clr = 1'b0;
   logic          overlap = 1'b0;
   logic          cfg_we = 1'b0;
   logic [0:0]    cfg_idx = '0;
   logic [N-1:0]  cfg_pattern = '0;
   logic [N-1:0]  cfg_mask = '0;
   logic [NP-1:0] det_o, det_o2;
   logic          det_any, det_any2;
   logic [7:0]    hit_cnt;
   logic [1:0]    hit_cnt2;

   always #5 clk = ~clk;

   seq_det_multi #(.N(N), .NUM_PAT(NP), .CNT_W(8), .PAT_INIT(4'b1011)) dut (
      .clk(clk), .rstn(rstn), .xin_vld(xin_vld), .xin(xin), .clr(clr),
      .overlap(overlap), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .det_o(det_o), .det_any(det_any), .hit_cnt(hit_cnt)
   );

   seq_det_multi #(.N(N), .NUM_PAT(NP), .CNT_W(2), .PAT_INIT(4'b1011)) dut2 (
      .clk(clk), .rstn(rstn), .xin_vld(xin_vld), .xin(xin), .clr(clr),
      .overlap(overlap), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .det_o(det_o2), .det_any(det_any2), .hit_cnt(hit_cnt2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: bits collected since the last restart, newest at back.
   bit            mhist[$];
   logic [N-1:0]  mpat  [NP];
   logic [N-1:0]  mmask [NP];
   logic [NP-1:0] mdet;
   int            mcnt, mcnt2;

   typedef struct {
      bit            v;
      bit            x;
      bit            c;
      bit            o;
      logic [NP-1:0] det;
      int            cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_edge(input bit v, input bit x, input bit c, input bit we,
                                      input bit idx, input logic [N-1:0] p,
                                      input logic [N-1:0] m, input bit ovl);
      bit ok;
      mdet = '0;
      if (c) begin
         mhist.delete();
         mcnt  = 0;
         mcnt2 = 0;
      end else if (v) begin
         mhist.push_back(x);
         if (mhist.size() > N) void'(mhist.pop_front());
         if (mhist.size() == N) begin
            for (int s = 0; s < NP; s++) begin
               ok = 1'b1;
               for (int k = 0; k < N; k++) begin
                  // mhist[0] is the oldest bit, which lines up with pattern MSB
                  if (mmask[s][N-1-k] && (mhist[k] != mpat[s][N-1-k])) ok = 1'b0;
               end
               mdet[s] = ok;
            end
         end
         if (mdet != '0) begin
            if (mcnt < 255) mcnt++;
            if (mcnt2 < 3) mcnt2++;
            if (!ovl) mhist.delete();
         end
      end
      if (we) begin
         mpat[idx]  = p;
         mmask[idx] = m;
      end
   endfunction

   task automatic step(input bit v, input bit x, input bit c = 1'b0, input bit we = 1'b0,
                       input bit idx = 1'b0, input logic [N-1:0] p = '0,
                       input logic [N-1:0] m = '0);
      xin_vld = v; xin = x; clr = c; cfg_we = we;
      cfg_idx = idx; cfg_pattern = p; cfg_mask = m;
      @(posedge clk);
      model_edge(v, x, c, we, idx, p, m, overlap);
      #1;
      chk("model_det", det_o, mdet);
      chk("model_det_any", det_any, |mdet);
      chk("model_cnt", hit_cnt, mcnt);
      chk("model_det2", det_o2, mdet);
      chk("model_cnt2", hit_cnt2, mcnt2);
   endtask

   function automatic void add(input bit v, input bit x, input bit c, input bit o,
                               input logic [NP-1:0] d, input int cnt);
      vec_t r;
      r.v = v; r.x = x; r.c = c; r.o = o; r.det = d; r.cnt = cnt;
      tbl.push_back(r);
   endfunction

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) begin
         overlap = tbl[i].o;
         step(tbl[i].v, tbl[i].x, tbl[i].c);
         chk({tag, "_det"}, det_o, tbl[i].det);
         chk({tag, "_cnt"}, hit_cnt, tbl[i].cnt);
      end
      tbl.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] rp, rm;
      int exp5[5];
      exp5 = '{1, 2, 3, 3, 3};
      for (int s = 0; s < NP; s++) begin
         mpat[s]  = 4'b1011;
         mmask[s] = 4'b1111;
      end
      mdet = '0; mcnt = 0; mcnt2 = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_det", det_o, 0);
      chk("rst_det_any", det_any, 0);
      chk("rst_cnt", hit_cnt, 0);
      chk("rst_cnt2", hit_cnt2, 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Slot1 = 0000: must not hit until four real zeros have arrived
      overlap = 1'b1;
      step(0, 0, 0, 1, 1, 4'b0000, 4'b1111);
      add(1,0,0,1,2'b00,0); add(1,0,0,1,2'b00,0); add(1,0,0,1,2'b00,0);
      add(1,0,0,1,2'b10,1); add(1,1,0,1,2'b00,1); add(1,0,0,1,2'b00,1);
      add(1,1,0,1,2'b00,1); add(1,1,0,1,2'b01,2);
      run_tbl("fill");

      // Overlap vs non-overlap on 1011 (slot1 parked on 1111)
      step(0, 0, 1, 1, 1, 4'b1111, 4'b1111);
      chk("clr_cnt", hit_cnt, 0);
      add(1,1,0,1,2'b00,0); add(1,0,0,1,2'b00,0); add(1,1,0,1,2'b00,0);
      add(1,1,0,1,2'b01,1); add(1,0,0,1,2'b00,1); add(1,1,0,1,2'b00,1);
      add(1,1,0,1,2'b01,2);
      add(1,1,1,0,2'b00,0);
      add(1,1,0,0,2'b00,0); add(1,0,0,0,2'b00,0); add(1,1,0,0,2'b00,0);
      add(1,1,0,0,2'b01,1); add(1,0,0,0,2'b00,1); add(1,1,0,0,2'b00,1);
      add(1,1,0,0,2'b00,1);
      add(1,1,1,0,2'b00,0);
      add(1,1,0,0,2'b00,0); add(1,0,0,0,2'b00,0); add(1,1,0,0,2'b00,0);
      add(1,1,0,0,2'b01,1); add(1,1,0,0,2'b00,1); add(1,0,0,0,2'b00,1);
      add(1,1,0,0,2'b00,1); add(1,1,0,0,2'b01,2);
      run_tbl("ovl");

      // Valid gaps hold the history and force det_o low
      overlap = 1'b1;
      step(0, 0, 1);
      step(1, 1); step(1, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, i[0]);
         chk("gap_det", det_o, 0);
      end
      step(1, 1);
      chk("gap_early", det_o, 0);
      step(1, 1);
      chk("gap_hit", det_o, 2'b01);
      chk("gap_cnt", hit_cnt, 1);

      // Masked slot1 = 1xx1 on a run of ones
      step(0, 0, 1, 1, 1, 4'b1001, 4'b1001);
      for (int i = 0; i < 6; i++) begin
         step(1, 1);
         chk("mask_det", det_o, (i >= 3) ? 2'b10 : 2'b00);
         chk("mask_any", det_any, (i >= 3));
      end

      // Counter saturation on the 2-bit instance
      step(0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(1, 1);
         if (i >= 3) chk("sat_cnt2", hit_cnt2, exp5[i-3]);
      end
      chk("sat_cnt8", hit_cnt, 5);

      // clr beats a completing valid bit
      step(0, 0, 1);
      step(1, 1); step(1, 0); step(1, 1);
      step(1, 1, 1);
      chk("clr_pri_det", det_o, 0);
      chk("clr_pri_cnt", hit_cnt, 0);
      step(1, 1); step(1, 0); step(1, 1);
      chk("clr_after_early", det_o[0], 0);
      step(1, 1);
      chk("clr_after_hit", det_o[0], 1);

      // Config write on the hit edge: old pattern applies on that edge
      step(0, 0, 1);
      step(1, 1); step(1, 0); step(1, 1);
      step(1, 1, 0, 1, 0, 4'b1111, 4'b1111);
      chk("cfg_old", det_o[0], 1);
      step(1, 1);
      chk("cfg_mid", det_o[0], 0);
      step(1, 1);
      chk("cfg_new", det_o[0], 1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         overlap = ($urandom_range(0, 1) == 1);
         rp = N'($urandom);
         rm = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
              $urandom_range(0, 1), rp, rm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
